// File: rtl/dsp_job_scheduler_if.sv
// Requester/transform-core handshake bundle for dsp_job_scheduler.
// slave = scheduler side, master = requester/datapath side.
interface dsp_job_scheduler_if #(
  parameter int unsigned NUM_REQ = 2
);
  localparam int unsigned SEL_W  = 2 * NUM_REQ;
  localparam int unsigned TAG_W  = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned JOB_W  = 16;
  localparam int unsigned ERRC_W = 8;

  logic [NUM_REQ-1:0] req;
  logic [SEL_W-1:0]   sel_flat;
  logic [NUM_REQ-1:0] gnt;
  logic               in_valid;
  logic               dl_en;
  logic               dt_load;
  logic [CNT_W-1:0]   samp_cnt;
  logic               in_data_valid;
  logic               hwt_en;
  logic               dct_en;
  logic               dft_en;
  logic               out_data_valid;
  logic               out_ready;
  logic [TAG_W-1:0]   out_tag;
  logic               err;
  logic               busy;
  logic [JOB_W-1:0]   job_cnt;
  logic [ERRC_W-1:0]  err_cnt;

  modport slave (
    input  req, sel_flat, in_valid, out_ready,
    output gnt, dl_en, dt_load, samp_cnt, in_data_valid,
           hwt_en, dct_en, dft_en, out_data_valid, out_tag,
           err, busy, job_cnt, err_cnt
  );

  modport master (
    output req, sel_flat, in_valid, out_ready,
    input  gnt, dl_en, dt_load, samp_cnt, in_data_valid,
           hwt_en, dct_en, dft_en, out_data_valid, out_tag,
           err, busy, job_cnt, err_cnt
  );
endinterface

// File: rtl/dsp_job_scheduler.sv
// Round-robin job scheduler for the shared HWT/DCT/DFT transform core.
// Optional job/error statistics counters are built when JOB_STATS_EN is defined.
module dsp_job_scheduler #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned N_SAMPLES = 8,
  parameter int unsigned HWT_LAT   = 6,
  parameter int unsigned DFT_LAT   = 5,
  parameter int unsigned DCT_LAT   = 8
) (
  input logic              clock,
  input logic              rst,
  dsp_job_scheduler_if.slave bus
);
  localparam int unsigned TAG_W  = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned REQX_W = 4;
  localparam int unsigned SELX_W = 8;
  localparam int unsigned JOB_W  = 16;
  localparam int unsigned ERRC_W = 8;

  localparam logic [1:0] SEL_HWT = 2'b11;
  localparam logic [1:0] SEL_DFT = 2'b10;
  localparam logic [1:0] SEL_DCT = 2'b00;
  localparam logic [1:0] SEL_ILL = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LOAD,
    S_COMPUTE,
    S_DONE,
    S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [TAG_W-1:0]   last_q, last_d;
  logic [1:0]         sel_q, sel_d;
  logic [CNT_W-1:0]   samp_q, samp_d;
  logic [CNT_W-1:0]   lat_q, lat_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               dl_en_q, dl_en_d;
  logic               idv_q, idv_d;
  logic               hwt_q, hwt_d;
  logic               dct_q, dct_d;
  logic               dft_q, dft_d;
  logic               odv_q, odv_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic [REQX_W-1:0]  req_ext;
  logic [SELX_W-1:0]  sel_ext;
  logic [TAG_W-1:0]   cand;
  logic [TAG_W-1:0]   pick_idx;
  logic [1:0]         pick_sel;
  logic               pick_found;

  // Zero-extend to the 4-requester maximum so a 2-bit index selects cleanly.
  assign req_ext = REQX_W'(bus.req);
  assign sel_ext = SELX_W'(bus.sel_flat);

  function automatic logic [CNT_W-1:0] lat_of(input logic [1:0] s);
    case (s)
      SEL_HWT: return CNT_W'(HWT_LAT);
      SEL_DFT: return CNT_W'(DFT_LAT);
      default: return CNT_W'(DCT_LAT);
    endcase
  endfunction

  // Round-robin pick: first set request after last_gnt, wrapping.
  always_comb begin
    cand       = '0;
    pick_idx   = '0;
    pick_sel   = '0;
    pick_found = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = TAG_W'((32'(last_q) + off) % NUM_REQ);
      if (!pick_found && req_ext[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
        pick_sel   = sel_ext[{cand, 1'b0} +: 2];
      end
    end
  end

  // Next-state logic; registered outputs are derived from the next state.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    last_d  = last_q;
    sel_d   = sel_q;
    samp_d  = samp_q;
    lat_d   = lat_q;
    idv_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          tag_d   = pick_idx;
          last_d  = pick_idx;
          sel_d   = pick_sel;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        samp_d  = '0;
        state_d = (sel_q == SEL_ILL) ? S_ERR : S_LOAD;
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          if (samp_q == CNT_W'(N_SAMPLES - 1)) begin
            samp_d  = '0;
            idv_d   = 1'b1;
            lat_d   = lat_of(sel_q);
            state_d = S_COMPUTE;
          end else begin
            samp_d = samp_q + CNT_W'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (lat_q == CNT_W'(1)) begin
          lat_d   = '0;
          state_d = S_DONE;
        end else begin
          lat_d = lat_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    gnt_d   = (state_d == S_GRANT) ? (NUM_REQ'(1) << tag_d) : '0;
    dl_en_d = (state_d == S_LOAD);
    hwt_d   = (state_d == S_COMPUTE) && (sel_d == SEL_HWT);
    dct_d   = (state_d == S_COMPUTE) && (sel_d == SEL_DCT);
    dft_d   = (state_d == S_COMPUTE) && (sel_d == SEL_DFT);
    odv_d   = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers; reset also aborts any job in flight.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      last_q  <= TAG_W'(NUM_REQ - 1);
      sel_q   <= '0;
      samp_q  <= '0;
      lat_q   <= '0;
      gnt_q   <= '0;
      dl_en_q <= 1'b0;
      idv_q   <= 1'b0;
      hwt_q   <= 1'b0;
      dct_q   <= 1'b0;
      dft_q   <= 1'b0;
      odv_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      samp_q  <= samp_d;
      lat_q   <= lat_d;
      gnt_q   <= gnt_d;
      dl_en_q <= dl_en_d;
      idv_q   <= idv_d;
      hwt_q   <= hwt_d;
      dct_q   <= dct_d;
      dft_q   <= dft_d;
      odv_q   <= odv_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt            = gnt_q;
  assign bus.dl_en          = dl_en_q;
  assign bus.dt_load        = dl_en_q;
  assign bus.samp_cnt       = samp_q;
  assign bus.in_data_valid  = idv_q;
  assign bus.hwt_en         = hwt_q;
  assign bus.dct_en         = dct_q;
  assign bus.dft_en         = dft_q;
  assign bus.out_data_valid = odv_q;
  assign bus.out_tag        = tag_q;
  assign bus.err            = err_q;
  assign bus.busy           = busy_q;

`ifdef JOB_STATS_EN
  logic [JOB_W-1:0]  job_q;
  logic [ERRC_W-1:0] errc_q;

  // Completed jobs wrap; rejected jobs saturate.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      job_q  <= '0;
      errc_q <= '0;
    end else begin
      if (state_q == S_DONE && bus.out_ready) job_q <= job_q + JOB_W'(1);
      if (state_q == S_ERR && errc_q != {ERRC_W{1'b1}}) errc_q <= errc_q + ERRC_W'(1);
    end
  end

  assign bus.job_cnt = job_q;
  assign bus.err_cnt = errc_q;
`else
  assign bus.job_cnt = '0;
  assign bus.err_cnt = '0;
`endif

endmodule
